// File: rtl/event_arb_pkg.sv
// Shared types and field-offset helpers for the event FIFO arbiter.
// The drop statistics counter is enabled with EVENT_ARB_STATS_EN.
package event_arb_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DROP_W   = 16;
    localparam int TIME_LSB = 0;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int ch_lsb(input int time_w);
        return TIME_LSB + time_w;
    endfunction

    function automatic int lost_bit(input int time_w, input int ch_w);
        return ch_lsb(time_w) + ch_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping modulo N_CH.
module rr_arbiter
    import event_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [CH_W-1:0] gnt_idx
);

    logic [CH_W-1:0] idx;

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(ptr) + k) % N_CH);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/event_fifo_arbiter.sv
// Edge-captures per-channel time words and grants them round-robin
// into one FIFO write port. Drop counter built only with EVENT_ARB_STATS_EN.
module event_fifo_arbiter
    import event_arb_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int TIME_W = 11,
    localparam int CH_W   = ch_width(N_CH),
    localparam int DATA_W = 1 + CH_W + TIME_W
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   arm,
    input  logic [N_CH*TIME_W-1:0] ch_time,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [DATA_W-1:0]      fifo_data,
    output logic                   idle,
    output logic [DROP_W-1:0]      drop_count
);

    localparam int CH_LSB   = ch_lsb(TIME_W);
    localparam int LOST_BIT = lost_bit(TIME_W, CH_W);

    state_t            state;
    state_t            state_nx;
    logic [N_CH-1:0]   prev_valid;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   lost;
    logic [TIME_W-1:0] hold [N_CH];
    logic [CH_W-1:0]   rr_ptr;

    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   gnt_oh;
    logic [N_CH-1:0]   cap;
    logic [N_CH-1:0]   ovr;
    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_idx;
    logic              grant_en;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign rise     = ch_valid & ~prev_valid;
    assign grant_en = (state != OFF) && !fifo_full && gnt_valid;

    // A channel being granted this cycle frees its slot for a new capture.
    always_comb begin
        gnt_oh = '0;
        cap    = '0;
        ovr    = '0;
        if (grant_en) gnt_oh[gnt_idx] = 1'b1;
        if (state == RUN) begin
            cap = rise & (~pending | gnt_oh);
            ovr = rise & pending & ~gnt_oh;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            OFF:     if (arm) state_nx = RUN;
            RUN:     if (!arm) state_nx = DRAIN;
            DRAIN: begin
                if (arm) state_nx = RUN;
                else if (pending == '0) state_nx = OFF;
            end
            default: state_nx = OFF;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= OFF;
            prev_valid <= '0;
            pending    <= '0;
            lost       <= '0;
            rr_ptr     <= '0;
            fifo_wr_en <= 1'b0;
            fifo_data  <= '0;
            for (int i = 0; i < N_CH; i++) hold[i] <= '0;
        end else begin
            state      <= state_nx;
            prev_valid <= ch_valid;
            pending    <= (pending & ~gnt_oh) | cap;
            lost       <= (lost & ~gnt_oh) | ovr;
            fifo_wr_en <= grant_en;
            if (grant_en) begin
                fifo_data[LOST_BIT]            <= lost[gnt_idx];
                fifo_data[CH_LSB +: CH_W]      <= gnt_idx;
                fifo_data[TIME_LSB +: TIME_W]  <= hold[gnt_idx];
                rr_ptr <= (int'(gnt_idx) == N_CH - 1) ? '0
                                                      : gnt_idx + 1'b1;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (cap[i]) hold[i] <= ch_time[i*TIME_W +: TIME_W];
            end
        end
    end

    assign idle = (state == OFF) && (pending == '0);

`ifdef EVENT_ARB_STATS_EN
    localparam int SUM_W = DROP_W + 1;

    logic [DROP_W-1:0] drop_q;
    logic [SUM_W-1:0]  drop_sum;

    assign drop_sum = {1'b0, drop_q} + SUM_W'($countones(ovr));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else drop_q <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_event_fifo_arbiter.sv
// Self-checking bench: directed vector table, corner sequences and
// randomized traffic against a channel-level reference model.
module tb_event_fifo_arbiter;

    localparam int N_CH   = 4;
    localparam int TIME_W = 11;
    localparam int DW     = 14;
    localparam int S_OFF  = 0;
    localparam int S_RUN  = 1;
    localparam int S_DRN  = 2;

    logic                   clock    = 1'b0;
    logic                   reset_n  = 1'b0;
    logic                   arm      = 1'b0;
    logic                   fifo_full = 1'b0;
    logic [N_CH*TIME_W-1:0] ch_time  = '0;
    logic [N_CH-1:0]        ch_valid = '0;
    logic                   fifo_wr_en;
    logic [DW-1:0]          fifo_data;
    logic                   idle;
    logic [15:0]            drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    event_fifo_arbiter #(
        .N_CH   (N_CH),
        .TIME_W (TIME_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .arm        (arm),
        .ch_time    (ch_time),
        .ch_valid   (ch_valid),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .idle       (idle),
        .drop_count (drop_count)
    );

    // Reference model: per-channel slot {pending, word, lost}
    int              m_st;
    int              m_ptr;
    int              m_drop;
    logic [3:0]      m_pend;
    logic [3:0]      m_lost;
    logic [3:0]      m_prev;
    logic [10:0]     m_hold [4];
    logic            exp_wr;
    logic [DW-1:0]   exp_data;
    logic            exp_idle;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int drop_exp();
`ifdef EVENT_ARB_STATS_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_st   = S_OFF;
        m_ptr  = 0;
        m_drop = 0;
        m_pend = '0;
        m_lost = '0;
        m_prev = '0;
        for (int i = 0; i < 4; i++) m_hold[i] = '0;
        exp_wr   = 1'b0;
        exp_data = '0;
        exp_idle = 1'b1;
    endtask

    task automatic model_step();
        int         g;
        logic [3:0] rise;
        logic       any_pend;
        rise     = ch_valid & ~m_prev;
        any_pend = (m_pend != 4'b0);
        g = -1;
        if (m_st != S_OFF && !fifo_full) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        exp_wr = (g >= 0);
        if (g >= 0) begin
            exp_data  = {m_lost[g], 2'(g), m_hold[g]};
            m_pend[g] = 1'b0;
            m_lost[g] = 1'b0;
            m_ptr     = (g + 1) % 4;
        end
        if (m_st == S_RUN) begin
            for (int i = 0; i < 4; i++) begin
                if (rise[i]) begin
                    if (m_pend[i]) begin
                        m_lost[i] = 1'b1;
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        m_hold[i] = ch_time[i*TIME_W +: TIME_W];
                        m_pend[i] = 1'b1;
                    end
                end
            end
        end
        case (m_st)
            S_OFF:   if (arm) m_st = S_RUN;
            S_RUN:   if (!arm) m_st = S_DRN;
            default: begin
                if (arm) m_st = S_RUN;
                else if (!any_pend) m_st = S_OFF;
            end
        endcase
        m_prev   = ch_valid;
        exp_idle = (m_st == S_OFF) && (m_pend == 4'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("model wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        if (exp_wr) chk("model data", 32'(fifo_data), 32'(exp_data));
        chk("model idle", 32'(idle), 32'(exp_idle));
        chk("model drop", 32'(drop_count), 32'(drop_exp()));
    endtask

    typedef struct {
        logic          arm;
        logic [3:0]    valid;
        logic          full;
        logic          wr;
        logic [DW-1:0] data;
        logic          idle;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic [3:0] v,
                                input logic f, input logic w,
                                input logic [DW-1:0] d, input logic i);
        vec_t r;
        r.arm = a; r.valid = v; r.full = f;
        r.wr = w; r.data = d; r.idle = i;
        return r;
    endfunction

    vec_t tbl [20];
    int   writes;

    initial begin
        model_reset();
        tbl[0]  = mk(1, 4'b0000, 0, 0, 14'h0000, 0);
        tbl[1]  = mk(1, 4'b0100, 0, 0, 14'h0000, 0);
        tbl[2]  = mk(1, 4'b0100, 0, 1, 14'h1155, 0);
        for (int i = 3; i <= 10; i++) tbl[i] = mk(1, 4'b0100, 0, 0, 14'h0, 0);
        tbl[11] = mk(1, 4'b0000, 0, 0, 14'h0000, 0);
        tbl[12] = mk(1, 4'b1000, 0, 0, 14'h0000, 0);
        tbl[13] = mk(1, 4'b0000, 0, 1, 14'h1BAA, 0);
        tbl[14] = mk(1, 4'b1111, 0, 0, 14'h0000, 0);
        tbl[15] = mk(1, 4'b1111, 0, 1, 14'h0101, 0);
        tbl[16] = mk(1, 4'b1111, 0, 1, 14'h0A02, 0);
        tbl[17] = mk(1, 4'b1111, 0, 1, 14'h1155, 0);
        tbl[18] = mk(1, 4'b1111, 0, 1, 14'h1BAA, 0);
        tbl[19] = mk(1, 4'b0000, 0, 0, 14'h0000, 0);

        #12;
        chk("reset wr_en", 32'(fifo_wr_en), 32'd0);
        chk("reset data", 32'(fifo_data), 32'd0);
        chk("reset idle", 32'(idle), 32'd1);
        chk("reset drop", 32'(drop_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        ch_time = {11'h3AA, 11'h155, 11'h202, 11'h101};
        for (int i = 0; i < 20; i++) begin
            arm       = tbl[i].arm;
            ch_valid  = tbl[i].valid;
            fifo_full = tbl[i].full;
            tick();
            chk($sformatf("vec%0d wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].wr));
            if (tbl[i].wr)
                chk($sformatf("vec%0d data", i), 32'(fifo_data), 32'(tbl[i].data));
            chk($sformatf("vec%0d idle", i), 32'(idle), 32'(tbl[i].idle));
        end

        // Overrun under backpressure
        fifo_full = 1'b1;
        ch_time[11 +: 11] = 11'd5;
        ch_valid = 4'b0010; tick();
        ch_valid = 4'b0000; tick();
        ch_time[11 +: 11] = 11'd9;
        ch_valid = 4'b0010; tick();
        ch_valid = 4'b0000; tick();
        chk("full holds", 32'(fifo_wr_en), 32'd0);
        fifo_full = 1'b0; tick();
        chk("overrun wr", 32'(fifo_wr_en), 32'd1);
        chk("overrun word", 32'(fifo_data), 32'h2805);
`ifdef EVENT_ARB_STATS_EN
        chk("overrun drop", 32'(drop_count), 32'd1);
`else
        chk("overrun drop", 32'(drop_count), 32'd0);
`endif
        tick();
        chk("overrun single", 32'(fifo_wr_en), 32'd0);

        // Grant and capture on ch0 in the same cycle
        ch_time[0 +: 11] = 11'd3;
        ch_valid = 4'b0001; tick();
        fifo_full = 1'b1;
        ch_valid = 4'b0000; tick();
        fifo_full = 1'b0;
        ch_time[0 +: 11] = 11'd7;
        ch_valid = 4'b0001; tick();
        chk("same old wr", 32'(fifo_wr_en), 32'd1);
        chk("same old word", 32'(fifo_data), 32'h0003);
        ch_valid = 4'b0000; tick();
        chk("same new wr", 32'(fifo_wr_en), 32'd1);
        chk("same new word", 32'(fifo_data), 32'h0007);
        chk("same no drop", 32'(drop_count), 32'(drop_exp()));
        tick();

        // Disarm with three pending, rise during DRAIN ignored
        fifo_full = 1'b1;
        ch_valid = 4'b0111; tick();
        arm = 1'b0;
        ch_valid = 4'b0000; tick();
        fifo_full = 1'b0;
        ch_valid = 4'b1000;
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (fifo_wr_en) writes++;
            ch_valid = 4'b0000;
        end
        chk("drain writes", 32'(writes), 32'd3);
        chk("drain idle", 32'(idle), 32'd1);
        chk("drain drop", 32'(drop_count), 32'(drop_exp()));

        // Reset while a strobe is active
        arm = 1'b1; tick();
        ch_time[0 +: 11] = 11'h001;
        ch_valid = 4'b0001; tick();
        ch_valid = 4'b0000; tick();
        chk("strobe before reset", 32'(fifo_wr_en), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async rst wr_en", 32'(fifo_wr_en), 32'd0);
        chk("async rst data", 32'(fifo_data), 32'd0);
        chk("async rst idle", 32'(idle), 32'd1);
        chk("async rst drop", 32'(drop_count), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        ch_time[33 +: 11] = 11'h2AB;
        ch_valid = 4'b1000; tick();
        ch_valid = 4'b0000; tick();
        chk("post reset wr", 32'(fifo_wr_en), 32'd1);
        chk("post reset word", 32'(fifo_data), 32'h1AAB);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 3) == 0) ch_valid[i] = ~ch_valid[i];
                ch_time[i*TIME_W +: TIME_W] = TIME_W'($urandom);
            end
            fifo_full = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
